coef_expander: RTL

Double-buffered filter-coefficient expander for the speech synthesis datapath. It accepts 8-bit sign-magnitude compressed coefficients over a valid/ready handshake and expands each through the fixed 4-segment piecewise-linear curve to OUT_W-bit sign-magnitude. Expanded values are stored into the write half of a two-bank coefficient store. The lattice filter reads the other half, and the banks swap on an explicit frame-boundary strobe, so a coefficient set never changes mid-frame.

---
 rtl/coef_if.sv | 12 +
 rtl/coef_expander.sv | 75 +++++++
 2 files changed

// File: rtl/coef_if.sv
// coef_if: coefficient write handshake, frame swap and read port between producer/filter and coef_expander
interface coef_if #(parameter int OUT_W = 10, parameter int IDX_W = 4);
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic frame_ready;
  logic swap;
  logic [IDX_W-1:0] rd_idx;
  logic [OUT_W-1:0] rd_data;
  modport master(output in_data, in_valid, swap, rd_idx, input in_ready, frame_ready, rd_data);
  modport slave(input in_data, in_valid, swap, rd_idx, output in_ready, frame_ready, rd_data);
endinterface

// File: rtl/coef_expander.sv
// coef_expander: double-buffered piecewise-linear coefficient expander; XLAT_NEGZERO_FIX_EN forces sign 0 when m=0
module coef_expander #(
  parameter int OUT_W = 10,
  parameter int NCOEF = 12,
  parameter int IDX_W = 4
) (
  input logic clk,
  input logic rst,
  coef_if.slave bus
);
  localparam int CW = IDX_W + 1;
  localparam logic [CW-1:0] LAST = CW'(NCOEF);
  typedef enum logic [1:0] {FILL, DRAIN, FULL} state_t;
  state_t state;
  logic [CW-1:0] wr_cnt;
  logic act;
  logic stage_vld;
  logic [IDX_W-1:0] stage_idx;
  logic [OUT_W-1:0] stage_data;
  logic [OUT_W-1:0] mem [2][2**IDX_W];
  logic accept;
  logic sgn;
  logic [6:0] m;
  logic [8:0] e;
  assign m = bus.in_data[6:0];
  assign e = m < 7'd38 ? 9'({m, 3'b000}) :
             m < 7'd69 ? 9'd149 + {m, 2'b00} :
             m < 7'd97 ? 9'd287 + {1'b0, m, 1'b0} :
                         9'd384 + {2'b00, m};
`ifdef XLAT_NEGZERO_FIX_EN
  assign sgn = bus.in_data[7] & |m;
`else
  assign sgn = bus.in_data[7];
`endif
  assign bus.in_ready = wr_cnt != LAST;
  assign accept = bus.in_valid & bus.in_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      wr_cnt <= '0;
      act <= 1'b0;
      stage_vld <= 1'b0;
      stage_idx <= '0;
      stage_data <= '0;
      bus.frame_ready <= 1'b0;
      bus.rd_data <= '0;
    end else begin
      stage_vld <= accept;
      if (accept) begin
        stage_idx <= wr_cnt[IDX_W-1:0];
        stage_data <= OUT_W'({sgn, e}) << (OUT_W - 10);
        wr_cnt <= wr_cnt + 1'b1;
      end
      bus.rd_data <= {1'b0, bus.rd_idx} < LAST ? mem[act][bus.rd_idx] : '0;
      case (state)
        FILL: if (accept && wr_cnt == LAST - 1'b1) state <= DRAIN;
        DRAIN: begin
          state <= FULL;
          bus.frame_ready <= 1'b1;
        end
        FULL: if (bus.swap) begin
          state <= FILL;
          bus.frame_ready <= 1'b0;
          wr_cnt <= '0;
          act <= ~act;
        end
        default: state <= FILL;
      endcase
    end
  end
  // bank memory is deliberately unreset; the write bank is always the inactive one
  always_ff @(posedge clk) begin
    if (stage_vld) mem[~act][stage_idx] <= stage_data;
  end
endmodule
